// File: rtl/fc_layer_seq.sv
// Bit-serial fully-connected binary-input layer with step activation and an internal weight/bias bank.
// Define FC_LAYER_SAT_EN for saturating accumulation; otherwise sums wrap modulo 2^ACC_W.
module fc_layer_seq #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 4,
  parameter int WW    = 10,
  parameter int ACC_W = 16,
  parameter int AW    = $clog2(N_OUT*(N_IN+1))
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WW-1:0]          wr_data,
  input  logic                   start,
  input  logic [N_IN-1:0]        in_vec,
  output logic                   busy,
  output logic                   done,
  output logic [N_OUT-1:0]       act_out,
  output logic [N_OUT*ACC_W-1:0] sum_out
);

  localparam int DEPTH = N_OUT*(N_IN+1);
  localparam int CW    = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

  state_t                  state, state_nxt;
  logic [WW-1:0]           bank [DEPTH];
  logic [N_IN-1:0]         vec_q;
  logic [CW-1:0]           cnt;
  logic signed [ACC_W-1:0] acc    [N_OUT];
  logic signed [ACC_W-1:0] bias_v [N_OUT];
  logic signed [ACC_W-1:0] w_v    [N_OUT];
  logic                    wr_ok;

  function automatic logic signed [ACC_W-1:0] add_acc(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
`ifdef FC_LAYER_SAT_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Sign bits disagreeing means the true sum left the representable range.
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  // Writes are only honoured while idle and not colliding with a start.
  assign wr_ok = wr_en && !start && (state == IDLE) && (32'(wr_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (wr_ok) bank[wr_addr] <= wr_data;
  end

  always_comb begin
    for (int n = 0; n < N_OUT; n++) begin
      bias_v[n] = ACC_W'($signed(bank[AW'(n*(N_IN+1) + N_IN)]));
      w_v[n]    = '0;
      if (vec_q[cnt]) w_v[n] = ACC_W'($signed(bank[AW'(n*(N_IN+1)) + AW'(cnt)]));
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACC;
      ACC:     if (cnt == CW'(N_IN-1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      act_out <= '0;
      sum_out <= '0;
      cnt     <= '0;
      vec_q   <= '0;
      for (int n = 0; n < N_OUT; n++) acc[n] <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            vec_q <= in_vec;
            cnt   <= '0;
            busy  <= 1'b1;
            for (int n = 0; n < N_OUT; n++) acc[n] <= bias_v[n];
          end
        end
        ACC: begin
          for (int n = 0; n < N_OUT; n++) acc[n] <= add_acc(acc[n], w_v[n]);
          cnt <= cnt + CW'(1);
        end
        FIN: begin
          for (int n = 0; n < N_OUT; n++) begin
            sum_out[n*ACC_W +: ACC_W] <= acc[n];
            act_out[n]                <= ~acc[n][ACC_W-1];
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Randomised bench for fc_layer_seq: two instances (ACC_W=16 and ACC_W=12) checked every cycle against a transaction-level model.
module tb_fc_layer_seq;

  localparam int N_IN  = 16;
  localparam int N_OUT = 4;
  localparam int WW    = 10;
  localparam int AW    = 7;
  localparam int DEPTH = 68;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, start;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic [15:0]   in_vec;
  logic          busy_a, done_a, busy_b, done_b;
  logic [3:0]    act_a, act_b;
  logic [63:0]   sum_a;
  logic [47:0]   sum_b;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  fc_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .WW(WW), .ACC_W(16)) dut_a (
    .clk(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .in_vec(in_vec), .busy(busy_a), .done(done_a), .act_out(act_a), .sum_out(sum_a));

  fc_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .WW(WW), .ACC_W(12)) dut_b (
    .clk(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .in_vec(in_vec), .busy(busy_b), .done(done_b), .act_out(act_b), .sum_out(sum_b));

  // Reference model: bank image, arithmetic sums computed when a start is accepted,
  // revealed after the fixed evaluation latency.
  logic [WW-1:0] bank_m [DEPTH];
  int            rem = 0;
  logic          exp_busy = 1'b0, exp_done = 1'b0;
  logic [3:0]    exp_act_a = '0, exp_act_b = '0, pend_act_a, pend_act_b;
  logic [63:0]   exp_sum_a = '0, pend_sum_a;
  logic [47:0]   exp_sum_b = '0, pend_sum_b;

  function automatic longint fit(longint s, int aw);
    longint span, half, m;
    span = longint'(1) << aw;
    half = span >> 1;
`ifdef FC_LAYER_SAT_EN
    m = s;
    if (s > half - 1) m = half - 1;
    if (s < -half) m = -half;
`else
    m = s & (span - 1);
    if (m >= half) m = m - span;
`endif
    return m;
  endfunction

  function automatic longint ref_sum(int n, logic [15:0] v, int aw);
    longint s;
    s = fit(longint'($signed(bank_m[n*17+16])), aw);
    for (int i = 0; i < 16; i++)
      if (v[i]) s = fit(s + longint'($signed(bank_m[n*17+i])), aw);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem = 0; exp_busy = 1'b0; exp_done = 1'b0;
      exp_act_a = '0; exp_act_b = '0; exp_sum_a = '0; exp_sum_b = '0;
    end else begin
      exp_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          exp_sum_a = pend_sum_a; exp_sum_b = pend_sum_b;
          exp_act_a = pend_act_a; exp_act_b = pend_act_b;
          exp_done  = 1'b1;
        end
      end else if (start) begin
        for (int n = 0; n < 4; n++) begin
          longint sa, sb;
          sa = ref_sum(n, in_vec, 16);
          sb = ref_sum(n, in_vec, 12);
          pend_sum_a[n*16 +: 16] = sa[15:0];
          pend_sum_b[n*12 +: 12] = sb[11:0];
          pend_act_a[n] = (sa >= 0);
          pend_act_b[n] = (sb >= 0);
        end
        rem = N_IN + 1;
      end else if (wr_en && int'(wr_addr) < DEPTH) begin
        bank_m[wr_addr] = wr_data;
      end
      exp_busy = (rem > 0);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_vec++;
      if ({busy_a, done_a, act_a, sum_a, busy_b, done_b, act_b, sum_b} !==
          {exp_busy, exp_done, exp_act_a, exp_sum_a, exp_busy, exp_done, exp_act_b, exp_sum_b}) begin
        n_err++;
        $display("FAIL cycle_check t=%0t got busy=%b/%b done=%b/%b act=%b/%b sum=%h/%h want busy=%b done=%b act=%b/%b sum=%h/%h",
                 $time, busy_a, busy_b, done_a, done_b, act_a, act_b, sum_a, sum_b,
                 exp_busy, exp_done, exp_act_a, exp_act_b, exp_sum_a, exp_sum_b);
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic longint sa(int n);
    return longint'($signed(sum_a[n*16 +: 16]));
  endfunction

  function automatic longint sb(int n);
    return longint'($signed(sum_b[n*12 +: 12]));
  endfunction

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 7'(a); wr_data = 10'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // dis: cycle (after the start edge) at which a stray start+write to bias[0] is pulsed; 0 = none.
  task automatic run(input logic [15:0] v, input int dis, input bit wr_too, output int lat);
    @(negedge clk);
    start = 1'b1; in_vec = v;
    if (wr_too) begin wr_en = 1'b1; wr_addr = 7'd16; wr_data = 10'd100; end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; in_vec = 16'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done_a) begin lat = k; break; end
      if (k == dis) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 7'd16; wr_data = 10'd100;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
    end
    start = 1'b0; wr_en = 1'b0;
    if (lat < 0) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: got no done within 40 cycles, want done after 17");
    end
  endtask

  initial begin
    int lat, seen;
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; in_vec = '0;
    #12;
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_act", act_a, 0);
    check("reset_sum_a", longint'(sum_a), 0);
    check("reset_sum_b", longint'(sum_b), 0);
    @(negedge clk);
    rst = 1'b0; chk_on = 1'b1;

    for (int a = 0; a < DEPTH; a++) wr(a, (a % 17 == 16) ? 0 : 1);

    // All-ones weights, zero bias, all inputs set.
    run(16'hFFFF, 0, 1'b0, lat);
    check("t1_latency", lat, 17);
    for (int n = 0; n < 4; n++) begin
      check("t1_sum_a", sa(n), 16);
      check("t1_sum_b", sb(n), 16);
    end
    check("t1_act", act_a, 4'b1111);

    // Negative bias on neuron 2, half the inputs.
    wr(2*17+16, 10'h3F0);
    run(16'h00FF, 0, 1'b0, lat);
    check("t2_sum2", sa(2), -8);
    check("t2_sum0", sa(0), 8);
    check("t2_sum3", sa(3), 8);
    check("t2_act", act_a, 4'b1011);
    wr(2*17+16, 0);

    // Stray start + write while busy: ignored, bias[0] untouched.
    run(16'hFFFF, 4, 1'b0, lat);
    check("t3_latency", lat, 17);
    check("t3_sum0", sa(0), 16);
    run(16'hFFFF, 0, 1'b0, lat);
    check("t3_rerun_sum0", sa(0), 16);

    // Abort mid-evaluation with reset.
    @(negedge clk);
    start = 1'b1; in_vec = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_busy", busy_a, 0);
    check("t4_done", done_a, 0);
    check("t4_act", act_a, 0);
    check("t4_sum", longint'(sum_a), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_a || done_b) seen++;
    end
    check("t4_no_done", seen, 0);
    run(16'hFFFF, 0, 1'b0, lat);
    for (int n = 0; n < 4; n++) check("t4_rerun_sum", sa(n), 16);

    // Large weights: 16-bit fits, 12-bit overflows.
    for (int a = 0; a < DEPTH; a++) wr(a, (a % 17 == 16) ? 0 : 511);
    run(16'hFFFF, 0, 1'b0, lat);
    check("t5_sum_a", sa(0), 8176);
    check("t5_act_a", act_a, 4'b1111);
`ifdef FC_LAYER_SAT_EN
    for (int n = 0; n < 4; n++) check("t5_sum_b", sb(n), 2047);
    check("t5_act_b", act_b, 4'b1111);
`else
    for (int n = 0; n < 4; n++) check("t5_sum_b", sb(n), -16);
    check("t5_act_b", act_b, 4'b0000);
`endif

    // Out-of-range write and write colliding with start: both dropped.
    wr(68, 5);
    run(16'hFFFF, 0, 1'b1, lat);
    check("t6_sum0", sa(0), 8176);
    check("t6_sum1", sa(1), 8176);

    repeat (30) begin
      int nw;
      nw = $urandom_range(0, 8);
      repeat (nw) wr($urandom_range(0, 75), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(16'($urandom), $urandom_range(0, 20), 1'($urandom_range(0, 1)), lat);
      check("rand_latency", lat, 17);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
